// File: rtl/ex_mem_stage_reg_pkg.sv
// ex_mem_stage_reg_pkg: shared widths, EX/MEM payload layout and skid-buffer state encoding
//   WORD_SIZE        datapath width (alu result, store data, branch target)
//   REG_ADDR_W       register-file address width
//   EX_MEM_PAYLOAD_W packed payload width, fields laid out MSB-first:
//                    alu_result | store_data | branch_target | dest_reg |
//                    zero | branch | mem_read | mem_write | reg_write | mem_to_reg
package ex_mem_stage_reg_pkg;

    localparam int WORD_SIZE        = 32;
    localparam int REG_ADDR_W       = 5;
    localparam int EX_MEM_PAYLOAD_W = 3 * WORD_SIZE + REG_ADDR_W + 6;

    localparam int OFF_MEM_TO_REG = 0;
    localparam int OFF_REG_WRITE  = 1;
    localparam int OFF_MEM_WRITE  = 2;
    localparam int OFF_MEM_READ   = 3;
    localparam int OFF_BRANCH     = 4;
    localparam int OFF_ZERO       = 5;
    localparam int OFF_DEST       = 6;
    localparam int OFF_BTARGET    = OFF_DEST + REG_ADDR_W;
    localparam int OFF_STORE      = OFF_BTARGET + WORD_SIZE;
    localparam int OFF_ALU        = OFF_STORE + WORD_SIZE;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/pipe_skid_buffer.sv
// pipe_skid_buffer: generic 2-entry valid/ready skid buffer with registered in_ready
//   clk, rst        clock, asynchronous active-high reset
//   flush           synchronous squash of both entries (wins over accept/drain)
//   in_valid/ready  upstream handshake, in_data payload
//   out_valid/ready downstream handshake, out_data head payload
module pipe_skid_buffer
    import ex_mem_stage_reg_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    skid_state_e      state, state_nxt;
    logic [WIDTH-1:0] head_q, skid_q;
    logic             accept, drain;

    assign accept = in_valid & in_ready;
    assign drain  = out_valid & out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_EMPTY;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush) state_nxt = ST_EMPTY;
        else begin
            case (state)
                ST_EMPTY: state_nxt = accept ? ST_FULL : ST_EMPTY;
                ST_FULL:  state_nxt = (accept & ~drain) ? ST_SKID :
                                      (~accept & drain) ? ST_EMPTY : ST_FULL;
                ST_SKID:  state_nxt = drain ? ST_FULL : ST_SKID;
                default:  state_nxt = ST_EMPTY;
            endcase
        end
    end

    // Head reloads from the input when it is empty or being drained; otherwise an
    // accepted beat parks in the skid slot. Flush leaves stale data behind.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            skid_q <= '0;
        end else if (!flush) begin
            if (state == ST_SKID) begin
                if (drain) head_q <= skid_q;
            end else if (accept && (state == ST_EMPTY || drain)) head_q <= in_data;
            else if (accept) skid_q <= in_data;
        end
    end

    // Handshake outputs decode only the state register, so no input reaches them.
    always_comb begin
        in_ready  = state != ST_SKID;
        out_valid = state != ST_EMPTY;
        out_data  = head_q;
    end

endmodule

// File: rtl/ex_mem_stage_reg.sv
// ex_mem_stage_reg: EX/MEM pipeline register behind a skid buffer, with branch resolve and EX forwarding tap
//   clock_in, reset_in, flush_in        clock, async active-high reset, sync squash
//   ex_valid_in / ex_ready_out          upstream handshake from EX
//   alu_result_in .. mem_to_reg_in      EX payload (data and control)
//   mem_valid_out / mem_ready_in        downstream handshake toward MEM
//   alu_result_out .. mem_to_reg_out    head payload, controls gated by mem_valid_out
//   pc_src_out                          taken branch at head
//   fwd_valid_out, fwd_reg_out, fwd_data_out  forwarding tap from head
module ex_mem_stage_reg
    import ex_mem_stage_reg_pkg::*;
(
    input  logic                  clock_in,
    input  logic                  reset_in,
    input  logic                  flush_in,
    input  logic                  ex_valid_in,
    output logic                  ex_ready_out,
    input  logic [WORD_SIZE-1:0]  alu_result_in,
    input  logic                  zero_in,
    input  logic [WORD_SIZE-1:0]  store_data_in,
    input  logic [REG_ADDR_W-1:0] dest_reg_in,
    input  logic [WORD_SIZE-1:0]  branch_target_in,
    input  logic                  branch_in,
    input  logic                  mem_read_in,
    input  logic                  mem_write_in,
    input  logic                  reg_write_in,
    input  logic                  mem_to_reg_in,
    output logic                  mem_valid_out,
    input  logic                  mem_ready_in,
    output logic [WORD_SIZE-1:0]  alu_result_out,
    output logic [WORD_SIZE-1:0]  store_data_out,
    output logic [WORD_SIZE-1:0]  branch_target_out,
    output logic                  zero_out,
    output logic [REG_ADDR_W-1:0] dest_reg_out,
    output logic                  mem_read_out,
    output logic                  mem_write_out,
    output logic                  reg_write_out,
    output logic                  mem_to_reg_out,
    output logic                  pc_src_out,
    output logic                  fwd_valid_out,
    output logic [REG_ADDR_W-1:0] fwd_reg_out,
    output logic [WORD_SIZE-1:0]  fwd_data_out
);

    logic [EX_MEM_PAYLOAD_W-1:0] in_payload, head;
    logic                        head_valid;

    assign in_payload = {alu_result_in, store_data_in, branch_target_in, dest_reg_in,
                         zero_in, branch_in, mem_read_in, mem_write_in, reg_write_in,
                         mem_to_reg_in};

    pipe_skid_buffer #(.WIDTH(EX_MEM_PAYLOAD_W)) u_skid (
        .clk       (clock_in),
        .rst       (reset_in),
        .flush     (flush_in),
        .in_valid  (ex_valid_in),
        .in_ready  (ex_ready_out),
        .in_data   (in_payload),
        .out_valid (head_valid),
        .out_ready (mem_ready_in),
        .out_data  (head)
    );

    // Data fields pass through raw; every control bit is qualified by head_valid so
    // a flushed (stale) head can never trigger a memory op, writeback or branch.
    always_comb begin
        mem_valid_out     = head_valid;
        alu_result_out    = head[OFF_ALU +: WORD_SIZE];
        store_data_out    = head[OFF_STORE +: WORD_SIZE];
        branch_target_out = head[OFF_BTARGET +: WORD_SIZE];
        dest_reg_out      = head[OFF_DEST +: REG_ADDR_W];
        zero_out          = head[OFF_ZERO];
        mem_read_out      = head_valid & head[OFF_MEM_READ];
        mem_write_out     = head_valid & head[OFF_MEM_WRITE];
        reg_write_out     = head_valid & head[OFF_REG_WRITE];
        mem_to_reg_out    = head_valid & head[OFF_MEM_TO_REG];
        pc_src_out        = head_valid & head[OFF_BRANCH] & head[OFF_ZERO];
        fwd_valid_out     = head_valid & head[OFF_REG_WRITE] & ~head[OFF_MEM_TO_REG] &
                            (|head[OFF_DEST +: REG_ADDR_W]);
        fwd_reg_out       = head[OFF_DEST +: REG_ADDR_W];
        fwd_data_out      = head[OFF_ALU +: WORD_SIZE];
    end

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// tb_ex_mem_stage_reg: scoreboard-driven bench for the EX/MEM stage register
module tb_ex_mem_stage_reg;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] store;
        logic [31:0] btgt;
        logic [4:0]  dest;
        logic        zero;
        logic        br;
        logic        mr;
        logic        mw;
        logic        rw;
        logic        m2r;
    } pl_t;

    logic        clk = 1'b0;
    logic        rst, flush, ex_valid, mem_ready;
    pl_t         drv;
    logic        ex_ready_out, mem_valid_out;
    logic [31:0] alu_result_out, store_data_out, branch_target_out, fwd_data_out;
    logic        zero_out, mem_read_out, mem_write_out, reg_write_out, mem_to_reg_out;
    logic        pc_src_out, fwd_valid_out;
    logic [4:0]  dest_reg_out, fwd_reg_out;
    logic [145:0] all_out;

    int  n_checks = 0;
    int  n_fail   = 0;
    int  n_drained = 0;
    pl_t sb[$];
    pl_t exp_pl;
    logic [145:0] got_v, exp_v;

    always #5 clk = ~clk;

    ex_mem_stage_reg dut (
        .clock_in          (clk),
        .reset_in          (rst),
        .flush_in          (flush),
        .ex_valid_in       (ex_valid),
        .ex_ready_out      (ex_ready_out),
        .alu_result_in     (drv.alu),
        .zero_in           (drv.zero),
        .store_data_in     (drv.store),
        .dest_reg_in       (drv.dest),
        .branch_target_in  (drv.btgt),
        .branch_in         (drv.br),
        .mem_read_in       (drv.mr),
        .mem_write_in      (drv.mw),
        .reg_write_in      (drv.rw),
        .mem_to_reg_in     (drv.m2r),
        .mem_valid_out     (mem_valid_out),
        .mem_ready_in      (mem_ready),
        .alu_result_out    (alu_result_out),
        .store_data_out    (store_data_out),
        .branch_target_out (branch_target_out),
        .zero_out          (zero_out),
        .dest_reg_out      (dest_reg_out),
        .mem_read_out      (mem_read_out),
        .mem_write_out     (mem_write_out),
        .reg_write_out     (reg_write_out),
        .mem_to_reg_out    (mem_to_reg_out),
        .pc_src_out        (pc_src_out),
        .fwd_valid_out     (fwd_valid_out),
        .fwd_reg_out       (fwd_reg_out),
        .fwd_data_out      (fwd_data_out)
    );

    assign all_out = {mem_valid_out, alu_result_out, store_data_out, branch_target_out,
                      zero_out, dest_reg_out, mem_read_out, mem_write_out, reg_write_out,
                      mem_to_reg_out, pc_src_out, fwd_valid_out, fwd_reg_out, fwd_data_out};

    // Scoreboard: at the falling edge the inputs are stable and decide what the next
    // rising edge does. Accepted beats are queued; drained heads are popped and compared.
    always @(negedge clk) begin
        if (rst || flush) sb.delete();
        else begin
            if (mem_valid_out && mem_ready) begin
                n_checks++;
                n_drained++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_underflow: got head alu=%h, required no output", alu_result_out);
                end else begin
                    exp_pl = sb.pop_front();
                    got_v = {alu_result_out, store_data_out, branch_target_out, dest_reg_out,
                             zero_out, mem_read_out, mem_write_out, reg_write_out, mem_to_reg_out,
                             pc_src_out, fwd_valid_out, fwd_reg_out, fwd_data_out};
                    exp_v = {exp_pl.alu, exp_pl.store, exp_pl.btgt, exp_pl.dest,
                             exp_pl.zero, exp_pl.mr, exp_pl.mw, exp_pl.rw, exp_pl.m2r,
                             exp_pl.br & exp_pl.zero,
                             exp_pl.rw & ~exp_pl.m2r & (exp_pl.dest != 5'd0),
                             exp_pl.dest, exp_pl.alu};
                    if (got_v !== exp_v) begin
                        n_fail++;
                        $display("FAIL sb_head: got %h, required %h", got_v, exp_v);
                    end
                end
            end
            if (ex_valid && ex_ready_out) sb.push_back(drv);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic pl_t rand_pl();
        pl_t p;
        p = {$urandom, $urandom, $urandom, 5'($urandom), 6'($urandom)};
        return p;
    endfunction

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; ex_valid = 1'b0; mem_ready = 1'b0; drv = '0;
        repeat (2) tick();
        n_checks++;
        if (all_out !== '0 || ex_ready_out !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_init: got outs=%h ready=%b, required 0 ready=1", all_out, ex_ready_out);
        end
        rst = 1'b0;
        tick();
        drv = rand_pl(); drv.alu = 32'hA; ex_valid = 1'b1;
        tick();
        drv = rand_pl(); drv.alu = 32'hB;
        tick();
        ex_valid = 1'b0;
        n_checks++;
        if (ex_ready_out !== 1'b0 || mem_valid_out !== 1'b1 || alu_result_out !== 32'hA) begin
            n_fail++;
            $display("FAIL reset_fill_skid: got ready=%b valid=%b alu=%h, required 0 1 0000000a",
                     ex_ready_out, mem_valid_out, alu_result_out);
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if (all_out !== '0 || ex_ready_out !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_async: got outs=%h ready=%b, required 0 ready=1", all_out, ex_ready_out);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_single();
        mem_ready = 1'b1;
        drv = rand_pl(); drv.alu = 32'h0000_0010; ex_valid = 1'b1;
        tick();
        ex_valid = 1'b0;
        n_checks++;
        if (mem_valid_out !== 1'b1 || alu_result_out !== 32'h10) begin
            n_fail++;
            $display("FAIL single_out: got valid=%b alu=%h, required 1 00000010", mem_valid_out, alu_result_out);
        end
        tick();
        n_checks++;
        if (mem_valid_out !== 1'b0) begin
            n_fail++;
            $display("FAIL single_gone: got valid=%b, required 0", mem_valid_out);
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int d0;
        d0 = n_drained;
        mem_ready = 1'b0;
        drv = rand_pl(); drv.alu = 32'd1; ex_valid = 1'b1;
        tick();
        drv = rand_pl(); drv.alu = 32'd2;
        tick();
        n_checks++;
        if (ex_ready_out !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_ready_after_b: got %b, required 0", ex_ready_out);
        end
        drv = rand_pl(); drv.alu = 32'd3;
        tick();
        n_checks++;
        if (ex_ready_out !== 1'b0 || alu_result_out !== 32'd1 || mem_valid_out !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold: got ready=%b valid=%b alu=%h, required 0 1 00000001",
                     ex_ready_out, mem_valid_out, alu_result_out);
        end
        mem_ready = 1'b1;
        for (int i = 0; i < 10 && !ex_ready_out; i++) tick();
        n_checks++;
        if (ex_ready_out !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_ready_timeout: got %b, required 1", ex_ready_out);
        end
        tick();
        ex_valid = 1'b0;
        for (int i = 0; i < 10 && mem_valid_out; i++) tick();
        n_checks++;
        if (sb.size() != 0 || n_drained - d0 != 3) begin
            n_fail++;
            $display("FAIL bp_delivered: got pending=%0d drained=%0d, required 0 3", sb.size(), n_drained - d0);
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_branch();
        mem_ready = 1'b0;
        drv = rand_pl(); drv.br = 1'b1; drv.zero = 1'b1; drv.btgt = 32'h0040_0020; ex_valid = 1'b1;
        tick();
        ex_valid = 1'b0;
        n_checks++;
        if (pc_src_out !== 1'b1 || branch_target_out !== 32'h0040_0020) begin
            n_fail++;
            $display("FAIL branch_taken: got pc_src=%b tgt=%h, required 1 00400020", pc_src_out, branch_target_out);
        end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        drv.zero = 1'b0; ex_valid = 1'b1;
        tick();
        ex_valid = 1'b0;
        n_checks++;
        if (pc_src_out !== 1'b0 || mem_valid_out !== 1'b1) begin
            n_fail++;
            $display("FAIL branch_not_taken: got pc_src=%b valid=%b, required 0 1", pc_src_out, mem_valid_out);
        end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
    endtask

    task automatic test_flush();
        mem_ready = 1'b0;
        drv = rand_pl(); drv.mw = 1'b1; drv.rw = 1'b1; drv.m2r = 1'b0; drv.br = 1'b1;
        drv.zero = 1'b1; drv.dest = 5'd7; ex_valid = 1'b1;
        tick();
        tick();
        n_checks++;
        if (ex_ready_out !== 1'b0 || pc_src_out !== 1'b1 || fwd_valid_out !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_pre_skid: got ready=%b pc_src=%b fwd=%b, required 0 1 1",
                     ex_ready_out, pc_src_out, fwd_valid_out);
        end
        flush = 1'b1; mem_ready = 1'b1;
        tick();
        flush = 1'b0; ex_valid = 1'b0; mem_ready = 1'b0;
        n_checks++;
        if ({mem_valid_out, mem_write_out, reg_write_out, pc_src_out, fwd_valid_out} !== 5'b0 ||
            ex_ready_out !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_skid: got v/mw/rw/pc/fwd=%b ready=%b, required 00000 1",
                     {mem_valid_out, mem_write_out, reg_write_out, pc_src_out, fwd_valid_out}, ex_ready_out);
        end
        ex_valid = 1'b1;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0; ex_valid = 1'b0;
        tick();
        n_checks++;
        if (mem_valid_out !== 1'b0 || ex_ready_out !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_full_accept: got valid=%b ready=%b, required 0 1", mem_valid_out, ex_ready_out);
        end
    endtask

    task automatic test_forward();
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'b0;
            drv = rand_pl(); drv.rw = 1'b1; drv.alu = 32'hDEAD_BEEF;
            drv.dest = (i == 1) ? 5'd0 : 5'd8;
            drv.m2r = (i == 2);
            ex_valid = 1'b1;
            tick();
            ex_valid = 1'b0;
            n_checks++;
            if (fwd_valid_out !== (i == 0) || fwd_reg_out !== drv.dest || fwd_data_out !== 32'hDEAD_BEEF) begin
                n_fail++;
                $display("FAIL forward_case%0d: got fwd=%b reg=%0d data=%h, required %b %0d deadbeef",
                         i, fwd_valid_out, fwd_reg_out, fwd_data_out, (i == 0), drv.dest);
            end
            mem_ready = 1'b1;
            tick();
        end
        mem_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int d0;
        d0 = n_drained;
        for (int i = 0; i < 300; i++) begin
            drv = rand_pl();
            ex_valid = ($urandom_range(3) != 0);
            mem_ready = $urandom_range(1) == 1;
            tick();
        end
        ex_valid = 1'b0; mem_ready = 1'b1;
        for (int i = 0; i < 10 && mem_valid_out; i++) tick();
        n_checks++;
        if (sb.size() != 0 || mem_valid_out !== 1'b0 || n_drained == d0) begin
            n_fail++;
            $display("FAIL b2b_drain: got pending=%0d valid=%b drained=%0d, required 0 0 >0",
                     sb.size(), mem_valid_out, n_drained - d0);
        end
        mem_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_branch();
        test_flush();
        test_forward();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish within 200000 time units");
        $fatal(1);
    end

endmodule
